sram_access_ctrl: RTL and testbench
===================================

# sram_access_ctrl

Sequencing front end for `testing_sram`. Accepts single-byte read/write requests over a valid/ready handshake and turns each into a timed SRAM cycle: address and data setup, then a level `read`/`write` strobe, then recovery. Read data is returned on a one-cycle response pulse. Sits directly upstream of `testing_sram`, replacing the hand-driven strobes used at block level.

## Interface
- `ACCESS_CYCLES`, default 2: cycles the strobe is held high; legal range 1..15.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 16: byte address.
- `req_wdata` in 8: write data.
- `rsp_valid` out 1: one-cycle completion pulse, for reads and writes.
- `rsp_write` out 1: copy of the completed request's `req_write`.
- `rsp_rdata` out 8: captured read data; holds its value until the next read completes.
- `sram_read` out 1: connects to SRAM `read`.
- `sram_write` out 1: connects to SRAM `write`.
- `sram_addr` out 16: connects to SRAM `addr`.
- `sram_valueIn` out 8: connects to SRAM `valueIn`.
- `sram_valueOut` in 8: connects to SRAM `valueOut`.
- `dump_req` in 1: request a memory dump. Present only with `SRAM_CTRL_DUMP_EN`.
- `dump_num` in 1: dump file select. Present only with `SRAM_CTRL_DUMP_EN`.
- `sram_dump` out 1: connects to SRAM `dump`.
- `sram_dumpNum` out 1: connects to SRAM `dumpNum`.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RECOVER, DUMP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid && req_ready`: latch `req_write`, `req_addr` and `req_wdata` into registers that drive `sram_addr`/`sram_valueIn`, then go to SETUP.
- **SETUP** (1 cycle)
  - Address and data are stable; both strobes are 0.
  - Load the access counter with `ACCESS_CYCLES-1`; go to ACCESS.
- **ACCESS** (`ACCESS_CYCLES` cycles)
  - `sram_write` = latched write flag; `sram_read` = its inverse. Exactly one strobe is high.
  - The counter decrements each cycle. On the cycle where the counter is 0:
    - for a read, register `sram_valueOut` into `rsp_rdata`;
    - go to RECOVER.
- **RECOVER** (1 cycle)
  - Both strobes are 0 and the address is still held.
  - `rsp_valid` = 1 and `rsp_write` = latched flag.
  - Go to IDLE.
- **DUMP** (1 cycle)
  - `sram_dump` = 1 and `sram_dumpNum` = latched `dump_num`.
  - Go to IDLE.
- Simultaneous `dump_req` and `req_valid` in IDLE: the dump wins. `req_ready` is 0 in that cycle and the request stays pending.
- `sram_addr` and `sram_valueIn` change only on request acceptance; they hold the last value in IDLE.
- Request fields are ignored outside the accepting cycle.
- No address arithmetic: the address passes through unmodified at 16 bits.

## Timing
- Reset values:
  - state = IDLE;
  - `req_ready` = 1;
  - `rsp_valid`, `rsp_write` = 0;
  - `rsp_rdata` = 8'h00;
  - `sram_read`, `sram_write`, `sram_dump`, `sram_dumpNum` = 0;
  - `sram_addr` = 16'h0000;
  - `sram_valueIn` = 8'h00.
- Accept at edge E. SETUP is cycle E+1; ACCESS is E+2 .. E+1+`ACCESS_CYCLES`; `rsp_valid` is high in cycle E+2+`ACCESS_CYCLES`.
- `req_ready` returns in the following cycle. Throughput is one request per `ACCESS_CYCLES`+3 cycles.
- All outputs are registered; no combinational path from `req_*` to `sram_*`.
- Reset asserted mid-operation: strobes drop immediately (asynchronously), the in-flight request is discarded, and no `rsp_valid` is issued.
- Strobes are never high in SETUP or RECOVER, so address and data are stable for one full cycle around every strobe.

## Configuration
- `SRAM_CTRL_DUMP_EN` defined:
  - `dump_req`/`dump_num` ports and the DUMP state exist;
  - `sram_dump` pulses for one cycle per accepted dump.
- Undefined:
  - ports and state are omitted;
  - `sram_dump` and `sram_dumpNum` are tied to 0.

## Structure
- Package `sram_ctrl_pkg`:
  - `ADDR_W`=16, `DATA_W`=8;
  - `sram_ctrl_state_t` enum (IDLE, SETUP, ACCESS, RECOVER, DUMP).
- Sub-module `sram_access_timer`: loadable down-counter, 4 bits wide, with load, enable and zero outputs. Instantiated once.

## Test plan
- Reset with `ACCESS_CYCLES`=2:
  - all outputs at their reset values;
  - `req_ready`=1.
- Write 89@0, 210@59, 66@195 back-to-back:
  - each `sram_write` pulse is exactly 2 cycles wide, preceded and followed by one strobe-free cycle;
  - 3 `rsp_valid` pulses, each with `rsp_write`=1.
- Read @0, @59, @195 (against the SRAM model):
  - `rsp_rdata` = 89, 210, 66 respectively;
  - each `rsp_valid` fires exactly 5 cycles after acceptance.
- `req_valid` held high continuously:
  - `req_ready` is low during SETUP, ACCESS and RECOVER;
  - no request is dropped or duplicated across 4 transactions.
- Assert `rst` during ACCESS of a write to 300:
  - `sram_write` falls within the same cycle;
  - no `rsp_valid`;
  - the controller accepts the next request normally.
- With `SRAM_CTRL_DUMP_EN`, `dump_req`=1, `dump_num`=0 and `req_valid`=1 in the same IDLE cycle:
  - `sram_dump` pulses 1 cycle with `sram_dumpNum`=0;
  - the request is accepted the cycle after.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared widths and FSM state type for the SRAM access controller.
package sram_ctrl_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RECOVER,
    DUMP
  } sram_ctrl_state_t;
endpackage

// File: rtl/sram_access_timer.sv
// Loadable 4-bit down-counter that times the strobe phase; stops at zero.
module sram_access_timer
  import sram_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - CNT_ONE;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/sram_access_ctrl.sv
// Turns valid/ready byte requests into timed SRAM strobe cycles (setup, access, recover).
// Optional memory-dump path is compiled in when SRAM_CTRL_DUMP_EN is defined.
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              sram_read,
  output logic              sram_write,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_valueIn,
  input  logic [DATA_W-1:0] sram_valueOut,
`ifdef SRAM_CTRL_DUMP_EN
  input  logic              dump_req,
  input  logic              dump_num,
`endif
  output logic              sram_dump,
  output logic              sram_dumpNum
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ACCESS_CYCLES - 1);

  sram_ctrl_state_t  state_reg;
  logic              req_ready_reg;
  logic              wr_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              rsp_valid_reg;
  logic              rsp_write_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;
  logic              read_reg;
  logic              write_reg;
  logic              dump_hit;
  logic              timer_zero;

`ifdef SRAM_CTRL_DUMP_EN
  logic dump_reg;
  logic dump_num_reg;
  assign dump_hit = dump_req;
`else
  assign dump_hit = 1'b0;
`endif

  sram_access_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state_reg == SETUP),
    .en       (state_reg == ACCESS),
    .load_val (LOAD_VAL),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      req_ready_reg <= 1'b1;
      wr_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_write_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      read_reg      <= 1'b0;
      write_reg     <= 1'b0;
`ifdef SRAM_CTRL_DUMP_EN
      dump_reg      <= 1'b0;
      dump_num_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (dump_hit) begin
`ifdef SRAM_CTRL_DUMP_EN
            state_reg     <= DUMP;
            dump_reg      <= 1'b1;
            dump_num_reg  <= dump_num;
            req_ready_reg <= 1'b0;
`endif
          end else if (req_valid) begin
            state_reg     <= SETUP;
            req_ready_reg <= 1'b0;
            wr_reg        <= req_write;
            addr_reg      <= req_addr;
            wdata_reg     <= req_wdata;
          end
        end
        SETUP: begin
          state_reg <= ACCESS;
          write_reg <= wr_reg;
          read_reg  <= ~wr_reg;
        end
        ACCESS: begin
          if (timer_zero) begin
            state_reg     <= RECOVER;
            write_reg     <= 1'b0;
            read_reg      <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_write_reg <= wr_reg;
            if (!wr_reg) begin
              rsp_rdata_reg <= sram_valueOut;
            end
          end
        end
        RECOVER: begin
          state_reg     <= IDLE;
          rsp_valid_reg <= 1'b0;
          rsp_write_reg <= 1'b0;
          req_ready_reg <= 1'b1;
        end
`ifdef SRAM_CTRL_DUMP_EN
        DUMP: begin
          state_reg     <= IDLE;
          dump_reg      <= 1'b0;
          dump_num_reg  <= 1'b0;
          req_ready_reg <= 1'b1;
        end
`endif
        default: begin
          state_reg     <= IDLE;
          req_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  // A same-cycle dump request must withdraw ready so the pending request is not consumed.
  assign req_ready    = req_ready_reg & ~dump_hit;
  assign rsp_valid    = rsp_valid_reg;
  assign rsp_write    = rsp_write_reg;
  assign rsp_rdata    = rsp_rdata_reg;
  assign sram_read    = read_reg;
  assign sram_write   = write_reg;
  assign sram_addr    = addr_reg;
  assign sram_valueIn = wdata_reg;

`ifdef SRAM_CTRL_DUMP_EN
  assign sram_dump    = dump_reg;
  assign sram_dumpNum = dump_num_reg;
`else
  assign sram_dump    = 1'b0;
  assign sram_dumpNum = 1'b0;
`endif

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Self-checking bench for sram_access_ctrl: cycle-level expectation model plus directed literal checks.
module tb_sram_access_ctrl;

  localparam int AC = 2;
  localparam int P_IDLE = 0, P_SETUP = 1, P_ACCESS = 2, P_RECOVER = 3, P_DUMP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [7:0]  req_wdata = 8'h0;
  logic        rsp_valid, rsp_write;
  logic [7:0]  rsp_rdata;
  logic        sram_read, sram_write, sram_dump, sram_dumpNum;
  logic [15:0] sram_addr;
  logic [7:0]  sram_valueIn, sram_valueOut;
  logic        dump_req = 1'b0;
  logic        dump_num = 1'b0;

  int checks = 0;
  int errors = 0;

  sram_access_ctrl #(.ACCESS_CYCLES(AC)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_write     (rsp_write),
    .rsp_rdata     (rsp_rdata),
    .sram_read     (sram_read),
    .sram_write    (sram_write),
    .sram_addr     (sram_addr),
    .sram_valueIn  (sram_valueIn),
    .sram_valueOut (sram_valueOut),
`ifdef SRAM_CTRL_DUMP_EN
    .dump_req      (dump_req),
    .dump_num      (dump_num),
`endif
    .sram_dump     (sram_dump),
    .sram_dumpNum  (sram_dumpNum)
  );

  always #5 clk = ~clk;

  // Stand-in for the SRAM: combinational read, write on the clock while the strobe is high.
  logic [7:0] sram_mem [0:65535];
  assign sram_valueOut = sram_mem[sram_addr];
  always @(posedge clk) if (sram_write) sram_mem[sram_addr] <= sram_valueIn;

  // Transaction-level model: one outstanding request, phases derived from its start cycle.
  int         cyc = 0;
  bit         act_m = 0;
  int         e_m = 0;
  int         dump_cyc = -100;
  bit         w_m = 0, dn_m = 0;
  logic [15:0] a_m = 16'h0;
  logic [7:0]  d_m = 8'h0, rd_m = 8'h0;
  logic [7:0]  mem_m [0:65535];

  initial begin
    for (int i = 0; i < 65536; i++) begin
      sram_mem[i] = 8'h00;
      mem_m[i] = 8'h00;
    end
  end

  function automatic int phase(input int c);
    if (c == dump_cyc) return P_DUMP;
    if (act_m) begin
      if (c == e_m) return P_SETUP;
      if (c > e_m && c <= e_m + AC) return P_ACCESS;
      if (c == e_m + AC + 1) return P_RECOVER;
    end
    return P_IDLE;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    int ph;
    if (!rst) begin
      ph = phase(cyc);
      if (ph == P_ACCESS && cyc == e_m + AC && !w_m) rd_m = mem_m[a_m];
      if (ph == P_IDLE) begin
        if (dump_req) begin
          dump_cyc = cyc + 1;
          dn_m = dump_num;
        end else if (req_valid) begin
          act_m = 1;
          e_m = cyc + 1;
          w_m = req_write;
          a_m = req_addr;
          d_m = req_wdata;
          if (req_write) mem_m[a_m] = d_m;
        end
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    int ph;
    if (rst) begin
      act_m = 0; dump_cyc = -100; a_m = 16'h0; d_m = 8'h0; rd_m = 8'h0;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_write", rsp_write, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_strobes", {sram_read, sram_write, sram_dump, sram_dumpNum}, 0);
      chk("rst_sram_addr", sram_addr, 0);
      chk("rst_sram_valueIn", sram_valueIn, 0);
    end else begin
      ph = phase(cyc);
      chk("req_ready", req_ready, (ph == P_IDLE) && !dump_req);
      chk("sram_write", sram_write, (ph == P_ACCESS) && w_m);
      chk("sram_read", sram_read, (ph == P_ACCESS) && !w_m);
      chk("rsp_valid", rsp_valid, ph == P_RECOVER);
      if (ph == P_RECOVER) chk("rsp_write", rsp_write, w_m);
      chk("sram_addr", sram_addr, a_m);
      chk("sram_valueIn", sram_valueIn, d_m);
      chk("rsp_rdata", rsp_rdata, rd_m);
      chk("sram_dump", sram_dump, ph == P_DUMP);
      if (ph == P_DUMP) chk("sram_dumpNum", sram_dumpNum, dn_m);
`ifndef SRAM_CTRL_DUMP_EN
      chk("sram_dumpNum_tied", sram_dumpNum, 0);
`endif
    end
  end

  // Issue one request and wait for its response; lat counts cycles from accept cycle to response cycle inclusive.
  task automatic do_req(input bit w, input logic [15:0] a, input logic [7:0] d,
                        output logic [7:0] rdata, output int lat, output int strobes);
    int k;
    bit ok;
    @(posedge clk); #1;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
    ok = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready never high for addr %0d", a);
    end
    @(posedge clk); #1;
    k = cyc;
    req_valid = 0; req_write = ~w; req_addr = 16'hBEEF; req_wdata = 8'hEE;
    strobes = 0;
    ok = 0;
    for (int n = 0; n < 30 && !ok; n++) begin
      @(negedge clk);
      if (sram_write || sram_read) strobes++;
      if (rsp_valid) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: no rsp_valid for addr %0d", a);
    end
    lat = cyc - (k - 1) + 1;
    rdata = rsp_rdata;
    $display("txn %s addr=%0d wdata=%0d rdata=%0d lat=%0d strobes=%0d",
             w ? "WR" : "RD", a, d, rdata, lat, strobes);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rd;
    int          lat, strb, acc, rsps;
    logic [15:0] waddr [3];
    logic [7:0]  wdat [3];
    logic [7:0]  rexp [3];
    bit          hw [4];
    logic [15:0] ha [4];
    logic [7:0]  hd [4];
    waddr = '{16'd0, 16'd59, 16'd195};
    wdat  = '{8'd89, 8'd210, 8'd66};
    rexp  = '{8'd89, 8'd210, 8'd66};
    hw = '{1'b1, 1'b0, 1'b1, 1'b0};
    ha = '{16'd1000, 16'd1000, 16'd1001, 16'd1001};
    hd = '{8'h10, 8'h00, 8'h11, 8'h00};

    @(negedge clk); @(negedge clk);
    chk("reset_ready_lit", req_ready, 1);
    chk("reset_addr_lit", sram_addr, 16'h0000);
    @(posedge clk); #1 rst = 0;

    for (int i = 0; i < 3; i++) begin
      do_req(1'b1, waddr[i], wdat[i], rd, lat, strb);
      chk("write_strobe_width", strb, 2);
    end
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, waddr[i], 8'h00, rd, lat, strb);
      chk("read_data_lit", rd, rexp[i]);
      chk("read_latency_lit", lat, 5);
    end

    // req_valid held high across four transactions
    acc = 0; rsps = 0;
    @(posedge clk); #1;
    req_valid = 1; req_write = hw[0]; req_addr = ha[0]; req_wdata = hd[0];
    for (int n = 0; n < 60 && rsps < 4; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        rsps++;
        $display("txn hold rsp %0d write=%0d rdata=%0d", rsps, rsp_write, rsp_rdata);
      end
      if (req_ready && req_valid) begin
        @(posedge clk); #1;
        acc++;
        if (acc < 4) begin
          req_write = hw[acc]; req_addr = ha[acc]; req_wdata = hd[acc];
        end else begin
          req_valid = 0;
        end
      end
    end
    chk("hold_accepts", acc, 4);
    chk("hold_responses", rsps, 4);
    chk("hold_last_rdata_lit", rsp_rdata, 8'h11);

    // reset during the strobe phase of a write to 300
    @(posedge clk); #1;
    req_valid = 1; req_write = 1; req_addr = 16'd300; req_wdata = 8'h5A;
    @(negedge clk);
    @(posedge clk); #1 req_valid = 0;
    for (int n = 0; n < 10 && !sram_write; n++) @(negedge clk);
    chk("write_strobe_seen", sram_write, 1);
    @(posedge clk); #1 rst = 1;
    #1;
    chk("rst_strobe_drop", sram_write, 0);
    chk("rst_no_rsp", rsp_valid, 0);
    @(posedge clk); #1 rst = 0;
    rsps = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (rsp_valid) rsps++;
    end
    chk("rst_no_late_rsp", rsps, 0);
    $display("txn reset-abort addr=300");
    do_req(1'b0, 16'd59, 8'h00, rd, lat, strb);
    chk("post_rst_read_lit", rd, 8'd210);

`ifdef SRAM_CTRL_DUMP_EN
    @(posedge clk); #1;
    dump_req = 1; dump_num = 0; req_valid = 1; req_write = 0; req_addr = 16'd0;
    @(negedge clk);
    chk("dump_blocks_ready", req_ready, 0);
    @(posedge clk); #1 dump_req = 0;
    @(negedge clk);
    chk("dump_pulse", sram_dump, 1);
    chk("dump_num_lit", sram_dumpNum, 0);
    $display("txn DUMP num=0");
    do_req(1'b0, 16'd0, 8'h00, rd, lat, strb);
    chk("after_dump_read_lit", rd, 8'd89);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
